// File: rtl/fp_unpack_pkg.sv
// Shared floating-point constants and the operand class-flag bundle.
// Used by the unpack stage (fp_unpack, fp_classify) and by the final
// assembly stage, so both sides agree on the flag layout.
package fp_unpack_pkg;

    localparam int unsigned WIDTH = 32;  // total FP word width
    localparam int unsigned WEXP  = 8;   // exponent field width
    localparam int unsigned WSIG  = 24;  // significand width incl. hidden bit

    localparam logic [WEXP-1:0] INF_EXP = '1;  // exponent of inf/nan
    localparam logic [WEXP-1:0] WEXP_0  = '0;  // exponent of zero/denorm

    // Per-operand class flags
    typedef struct packed {
        logic inf;
        logic nan;
        logic signan;
        logic zero;
        logic denorm;
    } fp_flags_t;

    localparam int unsigned FLAGS_W = $bits(fp_flags_t);

endpackage

// File: rtl/fp_classify.sv
// Combinational classifier for one FP operand magnitude.
// Ports:
//   mag_i     operand without its sign bit (exponent and fraction fields)
//   flags_o   class flags, laid out as fp_flags_t
//   hidden_o  hidden significand bit (exp != 0)
//   effexp_o  effective exponent (1 for zero/denorm, else exp)
module fp_classify
    import fp_unpack_pkg::*;
#(
    parameter int unsigned WIDTH = fp_unpack_pkg::WIDTH,
    parameter int unsigned WEXP  = fp_unpack_pkg::WEXP,
    parameter int unsigned WSIG  = fp_unpack_pkg::WSIG
) (
    input  logic [WIDTH-2:0]   mag_i,
    output logic [FLAGS_W-1:0] flags_o,
    output logic               hidden_o,
    output logic [WEXP-1:0]    effexp_o
);

    logic [WEXP-1:0] exp_f;
    logic [WSIG-2:0] frac_f;
    logic            exp_ones;
    logic            exp_zero;
    logic            frac_zero;
    fp_flags_t       flags;

    assign exp_f     = mag_i[WIDTH-2 -: WEXP];
    assign frac_f    = mag_i[WSIG-2:0];
    assign exp_ones  = &exp_f;
    assign exp_zero  = ~|exp_f;
    assign frac_zero = ~|frac_f;

    always_comb begin
        flags        = '0;
        flags.inf    = exp_ones & frac_zero;
        flags.nan    = exp_ones & ~frac_zero;
        // Signalling NaN: quiet bit (fraction MSB) clear
        flags.signan = exp_ones & ~frac_zero & ~frac_f[WSIG-2];
        flags.zero   = exp_zero & frac_zero;
        flags.denorm = exp_zero & ~frac_zero;
    end

    assign flags_o  = flags;
    assign hidden_o = ~exp_zero;
    // Denormals share the scale of exponent 1
    assign effexp_o = exp_zero ? WEXP'(1) : exp_f;

endmodule

// File: rtl/fp_unpack.sv
// Two-stage FP add/sub operand unpack pipeline.
// S1 registers the raw operands, op and the per-operand classification.
// S2 registers the magnitude compare, big/small swap, exponent difference
// and effective operation; all outputs come straight from S2 registers.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       input handshake; a, b operands, op (0 add, 1 sub)
//   out_valid/out_ready     output handshake
//   sa, sb, afrac, bfrac    signs and raw fraction fields (NaN payload)
//   a*/b* class flags       inf, nan, signan, zero, denorm per operand
//   specinput               any inf or nan operand
//   abig                    |a| field > |b| field (strict)
//   bigexp, expdiff         effective exponent of larger, exponent difference
//   bigsig, smallsig        significands with hidden bit, swapped by abig
//   effop, opq              sa^sb^op, registered op
module fp_unpack
    import fp_unpack_pkg::*;
#(
    parameter int unsigned WIDTH = fp_unpack_pkg::WIDTH,
    parameter int unsigned WEXP  = fp_unpack_pkg::WEXP,
    parameter int unsigned WSIG  = fp_unpack_pkg::WSIG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sa,
    output logic             sb,
    output logic [WSIG-2:0]  afrac,
    output logic [WSIG-2:0]  bfrac,
    output logic             ainf,
    output logic             binf,
    output logic             anan,
    output logic             bnan,
    output logic             asignan,
    output logic             bsignan,
    output logic             azero,
    output logic             bzero,
    output logic             adenorm,
    output logic             bdenorm,
    output logic             specinput,
    output logic             abig,
    output logic [WEXP-1:0]  bigexp,
    output logic [WEXP-1:0]  expdiff,
    output logic [WSIG-1:0]  bigsig,
    output logic [WSIG-1:0]  smallsig,
    output logic             effop,
    output logic             opq
);

    // Handshake
    logic s1_valid_q, s2_valid_q;
    logic s2_load, s1_load;

    assign s2_load   = ~s2_valid_q | out_ready;
    assign in_ready  = ~s1_valid_q | s2_load;
    assign s1_load   = in_valid & in_ready;
    assign out_valid = s2_valid_q;

    // S1: classification of incoming operands
    fp_flags_t       fa_c, fb_c;
    logic            ha_c, hb_c;
    logic [WEXP-1:0] ea_c, eb_c;

    fp_classify #(.WIDTH(WIDTH), .WEXP(WEXP), .WSIG(WSIG)) u_class_a (
        .mag_i   (a[WIDTH-2:0]),
        .flags_o (fa_c),
        .hidden_o(ha_c),
        .effexp_o(ea_c)
    );

    fp_classify #(.WIDTH(WIDTH), .WEXP(WEXP), .WSIG(WSIG)) u_class_b (
        .mag_i   (b[WIDTH-2:0]),
        .flags_o (fb_c),
        .hidden_o(hb_c),
        .effexp_o(eb_c)
    );

    logic [WIDTH-1:0] a_q, b_q;
    logic             op_q;
    fp_flags_t        fa_q, fb_q;
    logic             ha_q, hb_q;
    logic [WEXP-1:0]  ea_q, eb_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_q <= '0;  b_q <= '0;  op_q <= 1'b0;
            fa_q <= '0; fb_q <= '0; ha_q <= 1'b0; hb_q <= 1'b0;
            ea_q <= '0; eb_q <= '0;
        end else begin
            if (in_ready) s1_valid_q <= in_valid;
            if (s1_load) begin
                a_q <= a;    b_q <= b;    op_q <= op;
                fa_q <= fa_c; fb_q <= fb_c; ha_q <= ha_c; hb_q <= hb_c;
                ea_q <= ea_c; eb_q <= eb_c;
            end
        end
    end

    // S2: compare and swap
    logic            abig_c;
    logic [WEXP-1:0] bigexp_c, smallexp_c;
    logic [WSIG-1:0] siga_c, sigb_c;

    always_comb begin
        abig_c     = a_q[WIDTH-2:0] > b_q[WIDTH-2:0];
        bigexp_c   = abig_c ? ea_q : eb_q;
        smallexp_c = abig_c ? eb_q : ea_q;
        siga_c     = {ha_q, a_q[WSIG-2:0]};
        sigb_c     = {hb_q, b_q[WSIG-2:0]};
    end

    logic             s2_en;
    logic             sa_q, sb_q, abig_q, effop_q, opq_q;
    logic [WSIG-2:0]  afrac_q, bfrac_q;
    fp_flags_t        fa2_q, fb2_q;
    logic [WEXP-1:0]  bigexp_q, expdiff_q;
    logic [WSIG-1:0]  bigsig_q, smallsig_q;

    // Bubbles do not disturb the held data
    assign s2_en = s2_load & s1_valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            sa_q <= 1'b0; sb_q <= 1'b0; afrac_q <= '0; bfrac_q <= '0;
            fa2_q <= '0;  fb2_q <= '0;  abig_q <= 1'b0;
            bigexp_q <= '0; expdiff_q <= '0; bigsig_q <= '0; smallsig_q <= '0;
            effop_q <= 1'b0; opq_q <= 1'b0;
        end else begin
            if (s2_load) s2_valid_q <= s1_valid_q;
            if (s2_en) begin
                sa_q       <= a_q[WIDTH-1];
                sb_q       <= b_q[WIDTH-1];
                afrac_q    <= a_q[WSIG-2:0];
                bfrac_q    <= b_q[WSIG-2:0];
                fa2_q      <= fa_q;
                fb2_q      <= fb_q;
                abig_q     <= abig_c;
                bigexp_q   <= bigexp_c;
                expdiff_q  <= bigexp_c - smallexp_c;
                bigsig_q   <= abig_c ? siga_c : sigb_c;
                smallsig_q <= abig_c ? sigb_c : siga_c;
                effop_q    <= a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ op_q;
                opq_q      <= op_q;
            end
        end
    end

    assign sa        = sa_q;
    assign sb        = sb_q;
    assign afrac     = afrac_q;
    assign bfrac     = bfrac_q;
    assign ainf      = fa2_q.inf;
    assign binf      = fb2_q.inf;
    assign anan      = fa2_q.nan;
    assign bnan      = fb2_q.nan;
    assign asignan   = fa2_q.signan;
    assign bsignan   = fb2_q.signan;
    assign azero     = fa2_q.zero;
    assign bzero     = fb2_q.zero;
    assign adenorm   = fa2_q.denorm;
    assign bdenorm   = fb2_q.denorm;
    assign specinput = fa2_q.inf | fb2_q.inf | fa2_q.nan | fb2_q.nan;
    assign abig      = abig_q;
    assign bigexp    = bigexp_q;
    assign expdiff   = expdiff_q;
    assign bigsig    = bigsig_q;
    assign smallsig  = smallsig_q;
    assign effop     = effop_q;
    assign opq       = opq_q;

endmodule
